// File: rtl/prbs_test_pkg.sv
// Shared definitions for the PRBS test controller.
// Holds the FSM state encoding, the default pattern and timeout, and the pattern byte selector.
package prbs_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PATT     = 3'd1,
    ST_PRBS     = 3'd2,
    ST_WAIT_DET = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [31:0] DEF_PATTERN = 32'hABCDEF23;
  localparam logic [7:0]  DEF_TMO_CYC = 8'd255;

  // Index 0 selects the most significant byte, so the word goes out MSB first.
  function automatic logic [7:0] pat_byte(input logic [31:0] pattern, input logic [1:0] idx);
    case (idx)
      2'd0:    return pattern[31:24];
      2'd1:    return pattern[23:16];
      2'd2:    return pattern[15:8];
      default: return pattern[7:0];
    endcase
  endfunction

endpackage

// File: rtl/prbs_test_ctrl_if.sv
// Stream and detector link between the test controller (master) and the
// external PRBS generator / pattern detector (slave).
interface prbs_test_ctrl_if;
  logic [7:0] prbs_byte;
  logic       prbs_en;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       det_start;
  logic       det_flag;

  modport master (
    input  prbs_byte, det_flag,
    output prbs_en, byte_out, byte_valid, det_start
  );

  modport slave (
    output prbs_byte, det_flag,
    input  prbs_en, byte_out, byte_valid, det_start
  );
endinterface

// File: rtl/prbs_test_ctrl.sv
// PRBS test controller: emits PATTERN n_rep times, then prbs_len generator bytes, then waits for the detector.
// Optional: define PRBS_TEST_CTRL_TIMEOUT_EN to bound the detector wait to TMO_CYC cycles.
module prbs_test_ctrl
  import prbs_test_pkg::*;
#(
  parameter logic [31:0] PATTERN = DEF_PATTERN,
  parameter logic [7:0]  TMO_CYC = DEF_TMO_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] n_rep,
  input  logic [7:0] prbs_len,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  prbs_test_ctrl_if.master link
);

  state_t     state, state_next;
  logic [7:0] n_rep_q, n_rep_next;
  logic [7:0] prbs_len_q, prbs_len_next;
  logic [7:0] rep_cnt, rep_cnt_next;
  logic [1:0] byte_idx, byte_idx_next;
  logic [7:0] prbs_cnt, prbs_cnt_next;
  logic       pass_next, timeout_next;
  logic [7:0] byte_out_next;
`ifdef PRBS_TEST_CTRL_TIMEOUT_EN
  logic [7:0] tmo_cnt, tmo_cnt_next;
`else
  logic       unused_tmo;
  assign unused_tmo = ^TMO_CYC;
`endif

  // Restart pulse is combinational so the detector is cleared in the accept cycle itself.
  assign link.det_start = rst && (state == ST_IDLE) && start;

  always_comb begin
    state_next    = state;
    n_rep_next    = n_rep_q;
    prbs_len_next = prbs_len_q;
    rep_cnt_next  = rep_cnt;
    byte_idx_next = byte_idx;
    prbs_cnt_next = prbs_cnt;
    pass_next     = pass;
    timeout_next  = timeout;
    byte_out_next = 8'h00;
`ifdef PRBS_TEST_CTRL_TIMEOUT_EN
    tmo_cnt_next  = tmo_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          n_rep_next    = n_rep;
          prbs_len_next = prbs_len;
          rep_cnt_next  = 8'd0;
          byte_idx_next = 2'd0;
          prbs_cnt_next = 8'd0;
          pass_next     = 1'b0;
          timeout_next  = 1'b0;
`ifdef PRBS_TEST_CTRL_TIMEOUT_EN
          tmo_cnt_next  = 8'd0;
`endif
          if (n_rep != 8'd0)         state_next = ST_PATT;
          else if (prbs_len != 8'd0) state_next = ST_PRBS;
          else                       state_next = ST_WAIT_DET;
        end
      end
      // Counters track the byte currently on byte_out; leave on the last one.
      ST_PATT: begin
        if (byte_idx == 2'd3) begin
          if (rep_cnt == n_rep_q - 8'd1) begin
            state_next = (prbs_len_q != 8'd0) ? ST_PRBS : ST_WAIT_DET;
          end else begin
            rep_cnt_next  = rep_cnt + 8'd1;
            byte_idx_next = 2'd0;
          end
        end else begin
          byte_idx_next = byte_idx + 2'd1;
        end
      end
      ST_PRBS: begin
        if (prbs_cnt == prbs_len_q - 8'd1) state_next = ST_WAIT_DET;
        else                               prbs_cnt_next = prbs_cnt + 8'd1;
      end
      ST_WAIT_DET: begin
        if (link.det_flag) begin
          pass_next  = 1'b1;
          state_next = ST_DONE;
        end
`ifdef PRBS_TEST_CTRL_TIMEOUT_EN
        else if (({1'b0, tmo_cnt} + 9'd1) >= {1'b0, TMO_CYC}) begin
          timeout_next = 1'b1;
          pass_next    = 1'b0;
          state_next   = ST_DONE;
        end else begin
          tmo_cnt_next = tmo_cnt + 8'd1;
        end
`endif
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    case (state_next)
      ST_PATT: byte_out_next = pat_byte(PATTERN, byte_idx_next);
      ST_PRBS: byte_out_next = link.prbs_byte;
      default: byte_out_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      n_rep_q         <= 8'd0;
      prbs_len_q      <= 8'd0;
      rep_cnt         <= 8'd0;
      byte_idx        <= 2'd0;
      prbs_cnt        <= 8'd0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      link.byte_out   <= 8'h00;
      link.byte_valid <= 1'b0;
      link.prbs_en    <= 1'b0;
`ifdef PRBS_TEST_CTRL_TIMEOUT_EN
      tmo_cnt         <= 8'd0;
`endif
    end else begin
      state           <= state_next;
      n_rep_q         <= n_rep_next;
      prbs_len_q      <= prbs_len_next;
      rep_cnt         <= rep_cnt_next;
      byte_idx        <= byte_idx_next;
      prbs_cnt        <= prbs_cnt_next;
      pass            <= pass_next;
      timeout         <= timeout_next;
      busy            <= (state_next != ST_IDLE);
      done            <= (state_next == ST_DONE);
      link.byte_out   <= byte_out_next;
      link.byte_valid <= (state_next == ST_PATT) || (state_next == ST_PRBS);
      link.prbs_en    <= (state_next == ST_PRBS);
`ifdef PRBS_TEST_CTRL_TIMEOUT_EN
      tmo_cnt         <= tmo_cnt_next;
`endif
    end
  end

endmodule
